// File: rtl/sfifo_param.sv
// sfifo_param: single-clock FIFO (w_en/din in, r_en/dout out, count, full/empty/almost flags, sticky overflow/underflow cleared by err_clr), registered or FWFT read
module sfifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 64,
  parameter int AF_LVL = 60,
  parameter int AE_LVL = 4,
  parameter int FWFT = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [DATA_W-1:0] din,
  input  logic              r_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count_nxt;
  logic wr_ok, rd_ok;
  always_comb begin
    wr_ok = w_en && !full;
    rd_ok = r_en && !empty;
    count_nxt = (wr_ok && !rd_ok) ? count + (AW+1)'(1) : (rd_ok && !wr_ok) ? count - (AW+1)'(1) : count;
  end
  always_ff @(posedge clk)
    if (!rst && wr_ok) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_ok);
      rd_ptr <= rd_ptr + AW'(rd_ok);
      count <= count_nxt;
      full <= count_nxt == (AW+1)'(DEPTH);
      empty <= count_nxt == '0;
      almost_full <= count_nxt >= (AW+1)'(AF_LVL);
      almost_empty <= count_nxt <= (AW+1)'(AE_LVL);
      overflow <= (w_en && full) || (overflow && !err_clr);
      underflow <= (r_en && empty) || (underflow && !err_clr);
    end
  end
  if (FWFT != 0) begin : g_fwft
    assign dout = empty ? '0 : mem[rd_ptr];
  end else begin : g_reg
    always_ff @(posedge clk)
      if (rst) dout <= '0;
      else if (rd_ok) dout <= mem[rd_ptr];
  end
endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param: directed scoreboard bench for a registered-read and an FWFT instance of sfifo_param
module tb_sfifo_param;
  logic clk = 1'b0, rst = 1'b1;
  logic w0 = 1'b0, r0 = 1'b0, c0 = 1'b0, w1 = 1'b0, r1 = 1'b0, c1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, q0, q1;
  logic f0, e0, af0, ae0, ov0, un0, f1, e1, af1, ae1, ov1, un1;
  logic [6:0] n0, n1;
  int tests = 0, fails = 0;
  logic [7:0] mq[$];
  logic [7:0] last;
  always #5 clk = ~clk;
  sfifo_param #(.FWFT(0)) u0 (
    .clk(clk), .rst(rst), .w_en(w0), .din(d0), .r_en(r0), .err_clr(c0), .dout(q0),
    .full(f0), .empty(e0), .almost_full(af0), .almost_empty(ae0), .count(n0),
    .overflow(ov0), .underflow(un0));
  sfifo_param #(.FWFT(1)) u1 (
    .clk(clk), .rst(rst), .w_en(w1), .din(d1), .r_en(r1), .err_clr(c1), .dout(q1),
    .full(f1), .empty(e1), .almost_full(af1), .almost_empty(ae1), .count(n1),
    .overflow(ov1), .underflow(un1));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset0();
    chk("rst_empty", 32'(e0), 1);
    chk("rst_aempty", 32'(ae0), 1);
    chk("rst_full", 32'(f0), 0);
    chk("rst_afull", 32'(af0), 0);
    chk("rst_count", 32'(n0), 0);
    chk("rst_dout", 32'(q0), 0);
    chk("rst_ovf", 32'(ov0), 0);
    chk("rst_udf", 32'(un0), 0);
  endtask
  initial begin
    step();
    rst = 1'b0;
    repeat (3) step();
    chk_reset0();
    chk("rst1_empty", 32'(e1), 1);
    chk("rst1_dout", 32'(q1), 0);
    for (int i = 0; i < 64; i++) begin
      w0 = 1'b1; d0 = 8'(i);
      step();
      mq.push_back(8'(i));
      chk("fill_count", 32'(n0), 32'(i + 1));
      chk("fill_afull", 32'(af0), 32'(i + 1 >= 60));
      chk("fill_full", 32'(f0), 32'(i == 63));
    end
    d0 = 8'h99;
    step();
    chk("ovf_set", 32'(ov0), 1);
    chk("ovf_count", 32'(n0), 64);
    w0 = 1'b0; c0 = 1'b1;
    step();
    c0 = 1'b0;
    chk("ovf_clr", 32'(ov0), 0);
    for (int i = 0; i < 64; i++) begin
      r0 = 1'b1;
      step();
      last = mq.pop_front();
      chk("drain_dout", 32'(q0), 32'(last));
    end
    r0 = 1'b0;
    chk("drain_empty", 32'(e0), 1);
    chk("drain_count", 32'(n0), 0);
    chk("drain_udf", 32'(un0), 0);
    for (int i = 0; i < 10; i++) begin
      w0 = 1'b1; d0 = 8'(8'h40 + i);
      step();
      mq.push_back(d0);
    end
    for (int i = 0; i < 200; i++) begin
      w0 = 1'b1; r0 = 1'b1; d0 = 8'(8'h80 + i);
      step();
      last = mq.pop_front();
      mq.push_back(d0);
      chk("steady_dout", 32'(q0), 32'(last));
      chk("steady_count", 32'(n0), 10);
      chk("steady_flags", {28'd0, f0, e0, af0, ae0}, 0);
    end
    w0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      last = mq.pop_front();
      chk("steady_drain", 32'(q0), 32'(last));
    end
    r0 = 1'b0;
    chk("steady_empty", 32'(e0), 1);
    w0 = 1'b1; r0 = 1'b1; d0 = 8'hA5;
    step();
    mq.push_back(8'hA5);
    w0 = 1'b0; r0 = 1'b0;
    chk("udf_set", 32'(un0), 1);
    chk("udf_count", 32'(n0), 1);
    chk("udf_dout_hold", 32'(q0), 32'(last));
    c0 = 1'b1;
    step();
    c0 = 1'b0;
    chk("udf_clr", 32'(un0), 0);
    r0 = 1'b1;
    step();
    last = mq.pop_front();
    chk("udf_read", 32'(q0), 32'(last));
    chk("udf_read_empty", 32'(e0), 1);
    c0 = 1'b1;
    step();
    r0 = 1'b0; c0 = 1'b0;
    chk("udf_set_wins", 32'(un0), 1);
    chk("udf_hold_dout", 32'(q0), 32'(last));
    c0 = 1'b1;
    step();
    c0 = 1'b0;
    chk("udf_clr2", 32'(un0), 0);
    w1 = 1'b1; d1 = 8'h11;
    step();
    w1 = 1'b0;
    chk("fwft_first", 32'(q1), 32'h11);
    chk("fwft_count1", 32'(n1), 1);
    w1 = 1'b1; d1 = 8'h22;
    step();
    w1 = 1'b0;
    chk("fwft_head_held", 32'(q1), 32'h11);
    r1 = 1'b1;
    step();
    r1 = 1'b0;
    chk("fwft_next", 32'(q1), 32'h22);
    r1 = 1'b1;
    step();
    r1 = 1'b0;
    chk("fwft_empty", 32'(e1), 1);
    chk("fwft_dout0", 32'(q1), 0);
    chk("fwft_udf", 32'(un1), 0);
    for (int i = 0; i < 30; i++) begin
      w0 = 1'b1; d0 = 8'(8'hC0 + i);
      step();
    end
    chk("pre_rst_count", 32'(n0), 30);
    r0 = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; w0 = 1'b0; r0 = 1'b0;
    mq.delete();
    chk_reset0();
    w0 = 1'b1; d0 = 8'h5A;
    step();
    w0 = 1'b0;
    mq.push_back(8'h5A);
    chk("post_rst_count", 32'(n0), 1);
    r0 = 1'b1;
    step();
    r0 = 1'b0;
    last = mq.pop_front();
    chk("post_rst_read", 32'(q0), 32'(last));
    chk("post_rst_empty", 32'(e0), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
